// File: rtl/tpsram_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tpsram_share_arbiter: shares one two-port SRAM between requesters A and B |
// |   with independent round-robin write/read arbitration and tagged return.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tpsram_share_arbiter #(
  parameter int AW               = 6,
  parameter int DW               = 8,
  parameter int RD_LATENCY       = 1,
  parameter int COLLISION_BYPASS = 1
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          i_req_wr_a,
  input  logic          i_req_wr_b,
  input  logic [AW-1:0] i_waddr_a,
  input  logic [AW-1:0] i_waddr_b,
  input  logic [DW-1:0] i_wd_a,
  input  logic [DW-1:0] i_wd_b,
  output logic          o_gnt_wr_a,
  output logic          o_gnt_wr_b,
  input  logic          i_req_rd_a,
  input  logic          i_req_rd_b,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic          o_gnt_rd_a,
  output logic          o_gnt_rd_b,
  output logic          o_rvalid_a,
  output logic          o_rvalid_b,
  output logic [DW-1:0] o_rd_a,
  output logic [DW-1:0] o_rd_b,
  output logic [AW-1:0] o_TPSRAM_WADDR,
  output logic [DW-1:0] o_TPSRAM_WD,
  output logic          o_TPSRAM_WEN,
  output logic [AW-1:0] o_TPSRAM_RADDR,
  output logic          o_TPSRAM_REN,
  input  logic [DW-1:0] i_TPSRAM_RD
);

  logic          gnt_wr_a, gnt_wr_b, gnt_rd_a, gnt_rd_b;
  logic          wr_fav_b, rd_fav_b;
  logic          wen_q, ren_q;
  logic [AW-1:0] waddr_q, raddr_q;
  logic [DW-1:0] wd_q;
  logic          tag0_own;
  logic          coll0;
  logic          fin_v, fin_own, fin_coll;
  logic [DW-1:0] fin_wd;
  logic          rvalid_a_q, rvalid_b_q;
  logic [DW-1:0] rd_a_q, rd_b_q;

  // A wins unless B is also requesting and the pointer currently favours B.
  assign gnt_wr_a = i_req_wr_a & (~i_req_wr_b | ~wr_fav_b);
  assign gnt_wr_b = i_req_wr_b & ~gnt_wr_a;
  assign gnt_rd_a = i_req_rd_a & (~i_req_rd_b | ~rd_fav_b);
  assign gnt_rd_b = i_req_rd_b & ~gnt_rd_a;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_fav_b <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wd_q     <= '0;
    end else begin
      wen_q <= gnt_wr_a | gnt_wr_b;
      if (gnt_wr_a) begin
        wr_fav_b <= 1'b1;
        waddr_q  <= i_waddr_a;
        wd_q     <= i_wd_a;
      end else if (gnt_wr_b) begin
        wr_fav_b <= 1'b0;
        waddr_q  <= i_waddr_b;
        wd_q     <= i_wd_b;
      end
    end
  end

  // REN doubles as the valid bit of the first tag stage.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_fav_b <= 1'b0;
      ren_q    <= 1'b0;
      raddr_q  <= '0;
      tag0_own <= 1'b0;
    end else begin
      ren_q    <= gnt_rd_a | gnt_rd_b;
      tag0_own <= gnt_rd_b;
      if (gnt_rd_a) begin
        rd_fav_b <= 1'b1;
        raddr_q  <= i_raddr_a;
      end else if (gnt_rd_b) begin
        rd_fav_b <= 1'b0;
        raddr_q  <= i_raddr_b;
      end
    end
  end

  assign coll0 = (COLLISION_BYPASS != 0) && wen_q && ren_q && (waddr_q == raddr_q);

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign fin_v    = ren_q;
      assign fin_own  = tag0_own;
      assign fin_coll = coll0;
      assign fin_wd   = wd_q;
    end else begin : g_latn
      localparam int N = RD_LATENCY - 1;
      logic [N-1:0]  v_q, own_q, coll_q;
      logic [DW-1:0] bwd_q [N];

      // The bypass data is captured in the SRAM cycle of the read and rides
      // along with the tag until the SRAM data is due.
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          v_q    <= '0;
          own_q  <= '0;
          coll_q <= '0;
          for (int k = 0; k < N; k++) bwd_q[k] <= '0;
        end else begin
          v_q[0]    <= ren_q;
          own_q[0]  <= tag0_own;
          coll_q[0] <= coll0;
          bwd_q[0]  <= wd_q;
          for (int k = 1; k < N; k++) begin
            v_q[k]    <= v_q[k-1];
            own_q[k]  <= own_q[k-1];
            coll_q[k] <= coll_q[k-1];
            bwd_q[k]  <= bwd_q[k-1];
          end
        end
      end

      assign fin_v    = v_q[N-1];
      assign fin_own  = own_q[N-1];
      assign fin_coll = coll_q[N-1];
      assign fin_wd   = bwd_q[N-1];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
    end else begin
      rvalid_a_q <= fin_v & ~fin_own;
      rvalid_b_q <= fin_v & fin_own;
      if (fin_v && !fin_own) rd_a_q <= fin_coll ? fin_wd : i_TPSRAM_RD;
      if (fin_v && fin_own)  rd_b_q <= fin_coll ? fin_wd : i_TPSRAM_RD;
    end
  end

  assign o_gnt_wr_a     = gnt_wr_a;
  assign o_gnt_wr_b     = gnt_wr_b;
  assign o_gnt_rd_a     = gnt_rd_a;
  assign o_gnt_rd_b     = gnt_rd_b;
  assign o_TPSRAM_WEN   = wen_q;
  assign o_TPSRAM_WADDR = waddr_q;
  assign o_TPSRAM_WD    = wd_q;
  assign o_TPSRAM_REN   = ren_q;
  assign o_TPSRAM_RADDR = raddr_q;
  assign o_rvalid_a     = rvalid_a_q;
  assign o_rvalid_b     = rvalid_b_q;
  assign o_rd_a         = rd_a_q;
  assign o_rd_b         = rd_b_q;

endmodule
`default_nettype wire

// File: tb/tb_tpsram_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for tpsram_share_arbiter: two DUTs (bypass on/off) each on a
// flow-through SRAM model, checked every cycle against a transaction model.
module tb_tpsram_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_wr_a = 0, req_wr_b = 0, req_rd_a = 0, req_rd_b = 0;
  logic [5:0] waddr_a = 0, waddr_b = 0, raddr_a = 0, raddr_b = 0;
  logic [7:0] wd_a = 0, wd_b = 0;

  // bypass-enabled DUT
  logic       gnt_wr_a, gnt_wr_b, gnt_rd_a, gnt_rd_b, rvalid_a, rvalid_b;
  logic [7:0] rd_a, rd_b, s_wd, s_rd;
  logic [5:0] s_waddr, s_raddr;
  logic       s_wen, s_ren;
  // bypass-disabled DUT
  logic       z_gnt_wr_a, z_gnt_wr_b, z_gnt_rd_a, z_gnt_rd_b, z_rvalid_a, z_rvalid_b;
  logic [7:0] z_rd_a, z_rd_b, z_wd, z_rd;
  logic [5:0] z_waddr, z_raddr;
  logic       z_wen, z_ren;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tpsram_share_arbiter #(.AW(6), .DW(8), .RD_LATENCY(1), .COLLISION_BYPASS(1)) dut (
    .CLK(clk), .RESETn(rst_n),
    .i_req_wr_a(req_wr_a), .i_req_wr_b(req_wr_b), .i_waddr_a(waddr_a), .i_waddr_b(waddr_b),
    .i_wd_a(wd_a), .i_wd_b(wd_b), .o_gnt_wr_a(gnt_wr_a), .o_gnt_wr_b(gnt_wr_b),
    .i_req_rd_a(req_rd_a), .i_req_rd_b(req_rd_b), .i_raddr_a(raddr_a), .i_raddr_b(raddr_b),
    .o_gnt_rd_a(gnt_rd_a), .o_gnt_rd_b(gnt_rd_b), .o_rvalid_a(rvalid_a), .o_rvalid_b(rvalid_b),
    .o_rd_a(rd_a), .o_rd_b(rd_b), .o_TPSRAM_WADDR(s_waddr), .o_TPSRAM_WD(s_wd),
    .o_TPSRAM_WEN(s_wen), .o_TPSRAM_RADDR(s_raddr), .o_TPSRAM_REN(s_ren), .i_TPSRAM_RD(s_rd));

  tpsram_share_arbiter #(.AW(6), .DW(8), .RD_LATENCY(1), .COLLISION_BYPASS(0)) dut_raw (
    .CLK(clk), .RESETn(rst_n),
    .i_req_wr_a(req_wr_a), .i_req_wr_b(req_wr_b), .i_waddr_a(waddr_a), .i_waddr_b(waddr_b),
    .i_wd_a(wd_a), .i_wd_b(wd_b), .o_gnt_wr_a(z_gnt_wr_a), .o_gnt_wr_b(z_gnt_wr_b),
    .i_req_rd_a(req_rd_a), .i_req_rd_b(req_rd_b), .i_raddr_a(raddr_a), .i_raddr_b(raddr_b),
    .o_gnt_rd_a(z_gnt_rd_a), .o_gnt_rd_b(z_gnt_rd_b), .o_rvalid_a(z_rvalid_a), .o_rvalid_b(z_rvalid_b),
    .o_rd_a(z_rd_a), .o_rd_b(z_rd_b), .o_TPSRAM_WADDR(z_waddr), .o_TPSRAM_WD(z_wd),
    .o_TPSRAM_WEN(z_wen), .o_TPSRAM_RADDR(z_raddr), .o_TPSRAM_REN(z_ren), .i_TPSRAM_RD(z_rd));

  function automatic logic [7:0] pre(int i);
    return (i < 7) ? 8'(i * 17) : 8'h00;
  endfunction

  // Flow-through SRAMs (RD_LATENCY=1): RD follows RADDR within the REN cycle.
  logic [7:0] mem1 [64];
  logic [7:0] mem0 [64];
  assign s_rd = mem1[s_raddr];
  assign z_rd = mem0[z_raddr];

  initial begin
    for (int i = 0; i < 64; i++) mem1[i] = pre(i);
    forever @(posedge clk) if (s_wen) mem1[s_waddr] <= s_wd;
  end
  initial begin
    for (int i = 0; i < 64; i++) mem0[i] = pre(i);
    forever @(posedge clk) if (z_wen) mem0[z_waddr] <= z_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { int due; bit own_b; logic [7:0] byp; logic [7:0] raw; } ret_t;
  ret_t       rq[$];
  logic [7:0] ref_mem [64];
  int         cyc;
  bit         fav_b_wr, fav_b_rd;
  bit         m_wen, m_ren, m_rv_a, m_rv_b;
  logic [5:0] m_waddr, m_raddr;
  logic [7:0] m_wd, m_rd_a, m_rd_b, m_rd_a_raw, m_rd_b_raw;

  initial begin
    bit ga, gb, ra, rb;
    logic [5:0] wa, ra_addr;
    logic [7:0] wdat, raw;
    ret_t r;
    for (int i = 0; i < 64; i++) ref_mem[i] = pre(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        rq.delete(); cyc = 0; fav_b_wr = 0; fav_b_rd = 0;
        m_wen = 0; m_ren = 0; m_rv_a = 0; m_rv_b = 0;
        m_waddr = 0; m_raddr = 0; m_wd = 0;
        m_rd_a = 0; m_rd_b = 0; m_rd_a_raw = 0; m_rd_b_raw = 0;
      end else begin
        cyc++;
        m_rv_a = 0; m_rv_b = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          r = rq.pop_front();
          if (r.own_b) begin m_rv_b = 1; m_rd_b = r.byp; m_rd_b_raw = r.raw; end
          else         begin m_rv_a = 1; m_rd_a = r.byp; m_rd_a_raw = r.raw; end
        end
        ga = req_wr_a && (!req_wr_b || !fav_b_wr);
        gb = req_wr_b && !ga;
        ra = req_rd_a && (!req_rd_b || !fav_b_rd);
        rb = req_rd_b && !ra;
        wa = ga ? waddr_a : waddr_b;
        wdat = ga ? wd_a : wd_b;
        ra_addr = ra ? raddr_a : raddr_b;
        if (ra || rb) begin
          // Read sees all earlier writes; a same-cycle write to the same
          // address is visible only through the bypass.
          raw = ref_mem[ra_addr];
          rq.push_back('{cyc + 1, rb, ((ga || gb) && wa == ra_addr) ? wdat : raw, raw});
          m_raddr = ra_addr;
        end
        if (ga || gb) begin
          ref_mem[wa] = wdat;
          m_waddr = wa; m_wd = wdat;
        end
        m_wen = ga || gb;
        m_ren = ra || rb;
        if (ga) fav_b_wr = 1; else if (gb) fav_b_wr = 0;
        if (ra) fav_b_rd = 1; else if (rb) fav_b_rd = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit ega, egb, era, erb;
    ega = req_wr_a && (!req_wr_b || !fav_b_wr);
    egb = req_wr_b && !ega;
    era = req_rd_a && (!req_rd_b || !fav_b_rd);
    erb = req_rd_b && !era;
    chk("gnt_wr_a", gnt_wr_a, ega);   chk("gnt_wr_b", gnt_wr_b, egb);
    chk("gnt_rd_a", gnt_rd_a, era);   chk("gnt_rd_b", gnt_rd_b, erb);
    chk("wen", s_wen, m_wen);         chk("ren", s_ren, m_ren);
    chk("waddr", s_waddr, m_waddr);   chk("wd", s_wd, m_wd);
    chk("raddr", s_raddr, m_raddr);
    chk("rvalid_a", rvalid_a, m_rv_a); chk("rvalid_b", rvalid_b, m_rv_b);
    chk("rd_a", rd_a, m_rd_a);        chk("rd_b", rd_b, m_rd_b);
    chk("raw_gnt_wr_a", z_gnt_wr_a, ega); chk("raw_gnt_rd_b", z_gnt_rd_b, erb);
    chk("raw_wen", z_wen, m_wen);     chk("raw_ren", z_ren, m_ren);
    chk("raw_rvalid_a", z_rvalid_a, m_rv_a); chk("raw_rvalid_b", z_rvalid_b, m_rv_b);
    chk("raw_rd_a", z_rd_a, m_rd_a_raw);     chk("raw_rd_b", z_rd_b, m_rd_b_raw);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    logic [5:0] cont_addr [4];
    logic [7:0] pipe_exp [8];
    cont_addr = '{6'h10, 6'h20, 6'h10, 6'h20};
    pipe_exp  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h66, 8'h3C};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_wen", s_wen, 0); chk("reset_ren", s_ren, 0);
    chk("reset_rd_a", rd_a, 0); chk("reset_rvalid_b", rvalid_b, 0);
    rst_n = 1'b1;
    step();

    // contention on the write channel
    req_wr_a = 1; waddr_a = 6'h10; wd_a = 8'hB1;
    req_wr_b = 1; waddr_b = 6'h20; wd_b = 8'hB2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_gnt_a", gnt_wr_a, (i % 2) == 0);
      chk("cont_gnt_b", gnt_wr_b, (i % 2) == 1);
      step();
      chk("cont_wen", s_wen, 1);
      chk("cont_waddr", s_waddr, cont_addr[i]);
      if (i == 3) begin req_wr_a = 0; req_wr_b = 0; end
    end
    step();

    // solo write then read by A
    req_wr_a = 1; waddr_a = 6'h05; wd_a = 8'hA5;
    @(negedge clk); chk("solo_gnt_wr_a", gnt_wr_a, 1);
    step(); req_wr_a = 0;
    chk("solo_wen", s_wen, 1); chk("solo_waddr", s_waddr, 6'h05); chk("solo_wd", s_wd, 8'hA5);
    req_rd_a = 1; raddr_a = 6'h05;
    @(negedge clk); chk("solo_gnt_rd_a", gnt_rd_a, 1);
    step(); req_rd_a = 0;
    chk("solo_rvalid_early", rvalid_a, 0);
    step();
    chk("solo_rvalid_a", rvalid_a, 1); chk("solo_rd_a", rd_a, 8'hA5); chk("solo_rvalid_b", rvalid_b, 0);
    step();
    chk("solo_pulse_end", rvalid_a, 0); chk("solo_rd_hold", rd_a, 8'hA5);

    // write by A in parallel with read by B
    req_wr_a = 1; waddr_a = 6'h01; wd_a = 8'h11;
    req_rd_b = 1; raddr_b = 6'h02;
    @(negedge clk); chk("par_gnt_wr_a", gnt_wr_a, 1); chk("par_gnt_rd_b", gnt_rd_b, 1);
    step(); req_wr_a = 0; req_rd_b = 0;
    step();
    chk("par_rvalid_b", rvalid_b, 1); chk("par_rd_b", rd_b, 8'h22);

    // same-address collision
    req_wr_a = 1; waddr_a = 6'h07; wd_a = 8'h3C;
    req_rd_b = 1; raddr_b = 6'h07;
    @(negedge clk); chk("col_gnt_wr_a", gnt_wr_a, 1); chk("col_gnt_rd_b", gnt_rd_b, 1);
    step(); req_wr_a = 0; req_rd_b = 0;
    step();
    chk("col_rvalid_b", rvalid_b, 1);
    chk("col_rd_b_bypass", rd_b, 8'h3C);
    chk("col_rd_b_raw", z_rd_b, 8'h00);

    // pipelined reads by B
    for (int k = 0; k <= 10; k++) begin
      if (k >= 2) begin
        chk("pipe_rvalid_b", rvalid_b, k <= 9);
        if (k <= 9) chk("pipe_rd_b", rd_b, pipe_exp[k-2]);
      end
      req_rd_b = (k < 8);
      raddr_b  = 6'(k);
      step();
    end
    req_rd_b = 0;

    // reset with reads in flight
    req_rd_a = 1; raddr_a = 6'h03; req_rd_b = 1; raddr_b = 6'h04;
    step(); step();
    #2;
    rst_n = 0; req_rd_a = 0; req_rd_b = 0;
    #1;
    chk("mid_rst_wen", s_wen, 0);       chk("mid_rst_ren", s_ren, 0);
    chk("mid_rst_waddr", s_waddr, 0);   chk("mid_rst_wd", s_wd, 0);
    chk("mid_rst_raddr", s_raddr, 0);
    chk("mid_rst_rvalid_a", rvalid_a, 0); chk("mid_rst_rvalid_b", rvalid_b, 0);
    chk("mid_rst_rd_a", rd_a, 0);       chk("mid_rst_rd_b", rd_b, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_rvalid_a", rvalid_a, 0); chk("post_rst_rvalid_b", rvalid_b, 0);
    end
    // write pointer favoured B before reset; it must favour A again
    req_wr_a = 1; req_wr_b = 1; waddr_a = 6'h30; waddr_b = 6'h31;
    @(negedge clk);
    chk("post_rst_gnt_wr_a", gnt_wr_a, 1); chk("post_rst_gnt_wr_b", gnt_wr_b, 0);
    step(); req_wr_a = 0; req_wr_b = 0;
    chk("post_rst_waddr", s_waddr, 6'h30);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
